// File: rtl/gpu_arb_pkg.sv
// Shared types and constants for the GPU RAM host-port arbiter.
package gpu_arb_pkg;
  localparam int MAX_REQ = 4;
  localparam int ADDR_W  = 20;

  typedef enum logic [1:0] {IDLE, ACCESS, RD_WAIT, RD_DONE} arb_state_t;

  // Index width that stays legal for a single requester.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/host_mem_arbiter_if.sv
// Requester bundle plus GPU RAM host port; slave = arbiter, master = requesters/memory side.
interface host_mem_arbiter_if
  import gpu_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]             req;
  logic [NUM_REQ-1:0]             req_wr;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0][7:0]        req_wdata;
  logic [NUM_REQ-1:0]             gnt;
  logic [NUM_REQ-1:0]             rd_valid;
  logic [7:0]                     rd_data;
  logic                           mem_wr_ena;
  logic [ADDR_W-1:0]              mem_addr;
  logic [7:0]                     mem_wr_data;
  logic [7:0]                     mem_rd_data;

  modport slave (
    input  req, req_wr, req_addr, req_wdata, mem_rd_data,
    output gnt, rd_valid, rd_data, mem_wr_ena, mem_addr, mem_wr_data
  );
  modport master (
    output req, req_wr, req_addr, req_wdata, mem_rd_data,
    input  gnt, rd_valid, rd_data, mem_wr_ena, mem_addr, mem_wr_data
  );
endinterface

// File: rtl/host_mem_arbiter_rr_picker.sv
// Round-robin winner search from ptr upward with wrap; HOST_ARB_PRIO0_EN makes requester 0 absolute.
module rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int IW      = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] win_oh,
  output logic [IW-1:0]      win_idx,
  output logic               win_any
);
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    win_any = |req;
    // Walk from farthest to nearest so the first set bit after ptr is the last write.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % NUM_REQ]) win_idx = IW'((int'(ptr) + k) % NUM_REQ);
    end
`ifdef HOST_ARB_PRIO0_EN
    if (req[0]) win_idx = '0;
`endif
    if (win_any) win_oh[win_idx] = 1'b1;
  end
endmodule

// File: rtl/host_mem_arbiter.sv
// Arbitrates NUM_REQ requesters onto the GPU RAM host port, one access per issue slot.
// Optional HOST_ARB_PRIO0_EN: requester 0 always wins and does not advance the rr pointer.
module host_mem_arbiter
  import gpu_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int RD_LAT     = 2,
  parameter int ISSUE_SLOT = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] pc_ena,
  host_mem_arbiter_if.slave bus
);
  localparam int IW = idx_w(NUM_REQ);

  arb_state_t         state, nxt;
  logic [IW-1:0]      rr_ptr, id, win_idx, nxt_ptr;
  logic [NUM_REQ-1:0] win_oh;
  logic               win_any, wr_l, issue;
  logic [2:0]         lat_cnt;

  rr_picker #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
    .req(bus.req), .ptr(rr_ptr), .win_oh(win_oh), .win_idx(win_idx), .win_any(win_any)
  );

  assign issue   = (state == IDLE) && (pc_ena == 4'(ISSUE_SLOT)) && win_any;
  assign nxt_ptr = (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (issue) nxt = ACCESS;
      ACCESS:  nxt = wr_l ? IDLE : RD_WAIT;
      RD_WAIT: if (lat_cnt == '0) nxt = RD_DONE;
      RD_DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr          <= '0;
      id              <= '0;
      wr_l            <= 1'b0;
      lat_cnt         <= '0;
      bus.gnt         <= '0;
      bus.rd_valid    <= '0;
      bus.rd_data     <= '0;
      bus.mem_wr_ena  <= 1'b0;
      bus.mem_addr    <= '0;
      bus.mem_wr_data <= '0;
    end else begin
      bus.gnt        <= '0;
      bus.rd_valid   <= '0;
      bus.mem_wr_ena <= 1'b0;
      if (issue) begin
        bus.gnt         <= win_oh;
        id              <= win_idx;
        wr_l            <= bus.req_wr[win_idx];
        bus.mem_wr_ena  <= bus.req_wr[win_idx];
        bus.mem_addr    <= bus.req_addr[win_idx];
        bus.mem_wr_data <= bus.req_wdata[win_idx];
`ifdef HOST_ARB_PRIO0_EN
        if (win_idx != '0) rr_ptr <= nxt_ptr;
`else
        rr_ptr <= nxt_ptr;
`endif
      end
      if (state == ACCESS) lat_cnt <= 3'(RD_LAT - 1);
      if (state == RD_WAIT && lat_cnt != '0) lat_cnt <= lat_cnt - 1'b1;
      // mem_addr is left untouched after issue so it stays held through the read.
      if (state == RD_DONE) begin
        bus.rd_data      <= bus.mem_rd_data;
        bus.rd_valid[id] <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_host_mem_arbiter.sv
// Bench for host_mem_arbiter: directed scenarios plus random traffic against a transaction-timing model.
module tb_host_mem_arbiter;
  import gpu_arb_pkg::*;
  localparam int N      = 3;
  localparam int RD_LAT = 3;
  localparam int SLOT   = 5;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] pc_ena = '0;

  host_mem_arbiter_if #(.NUM_REQ(N)) bus();

  host_mem_arbiter #(.NUM_REQ(N), .RD_LAT(RD_LAT), .ISSUE_SLOT(SLOT)) dut (
    .clk(clk), .reset_n(reset_n), .pc_ena(pc_ena), .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] memf(input logic [19:0] a);
    return a[7:0] ^ a[15:8] ^ {4'h0, a[19:16]} ^ 8'h2C;
  endfunction

  // Memory: data for an address appears RD_LAT clocks after it is driven.
  logic [19:0] ahist [RD_LAT];
  always @(posedge clk) begin
    for (int j = RD_LAT - 1; j > 0; j--) ahist[j] <= ahist[j-1];
    ahist[0] <= bus.mem_addr;
  end
  assign bus.mem_rd_data = memf(ahist[RD_LAT-1]);

  int nerr = 0, nchk = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct { int due; int id; logic [7:0] d; } rd_t;
  rd_t rq[$];
  int  glog[$], rdlog[$];
  int  cyc, free_at, ptr, mw, mode, gcyc, rcyc, wrcnt;
  logic [N-1:0] e_gnt, e_rdv;
  logic         e_wr;
  logic [19:0]  e_addr;
  logic [7:0]   e_wd, e_rdd, last_rdd;

  task automatic model_reset();
    rq.delete();
    cyc = 0; free_at = 0; ptr = 0; mw = -1;
    e_gnt = '0; e_rdv = '0; e_wr = 1'b0; e_addr = '0; e_wd = '0; e_rdd = '0;
  endtask

  // Inputs for cycle cyc are stable here; derive what the next cycle must show.
  task automatic predict();
    int w, g;
    w = -1; mw = -1;
    e_gnt = '0; e_wr = 1'b0; e_rdv = '0;
    if (rq.size() > 0 && rq[0].due == cyc + 1) begin
      e_rdv[rq[0].id] = 1'b1;
      e_rdd = rq[0].d;
      void'(rq.pop_front());
    end
    if (cyc >= free_at && pc_ena == 4'(SLOT) && |bus.req) begin
`ifdef HOST_ARB_PRIO0_EN
      if (bus.req[0]) w = 0;
`endif
      for (int k = 0; k < N; k++)
        if (w < 0 && bus.req[(ptr + k) % N]) w = (ptr + k) % N;
      e_gnt[w] = 1'b1;
      e_wr     = bus.req_wr[w];
      e_addr   = bus.req_addr[w];
      e_wd     = bus.req_wdata[w];
`ifdef HOST_ARB_PRIO0_EN
      if (w != 0) ptr = (w + 1) % N;
`else
      ptr = (w + 1) % N;
`endif
      g = cyc + 1;
      if (e_wr) free_at = g + 1;
      else begin
        free_at = g + RD_LAT + 2;
        rq.push_back('{g + RD_LAT + 2, w, memf(e_addr)});
      end
      mw = w;
    end
    cyc++;
  endtask

  task automatic cycle_chk();
    chk("gnt", 32'(bus.gnt), 32'(e_gnt));
    chk("mem_wr_ena", 32'(bus.mem_wr_ena), 32'(e_wr));
    chk("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
    chk("mem_wr_data", 32'(bus.mem_wr_data), 32'(e_wd));
    chk("rd_valid", 32'(bus.rd_valid), 32'(e_rdv));
    chk("rd_data", 32'(bus.rd_data), 32'(e_rdd));
    for (int i = 0; i < N; i++) begin
      if (bus.gnt[i])      begin glog.push_back(i); gcyc = cyc; end
      if (bus.rd_valid[i]) begin rdlog.push_back(i); rcyc = cyc; last_rdd = bus.rd_data; end
    end
    if (bus.mem_wr_ena) wrcnt++;
  endtask

  task automatic new_access(input int i);
    bus.req[i]       = 1'b1;
    bus.req_wr[i]    = 1'($urandom_range(0, 1));
    bus.req_addr[i]  = 20'($urandom);
    bus.req_wdata[i] = 8'($urandom);
  endtask

  task automatic req_update();
    if (mode == 0 && mw >= 0) bus.req[mw] = 1'b0;
    if (mode == 2)
      for (int i = 0; i < N; i++) begin
        if (mw == i) begin
          if ($urandom_range(0, 1) == 1) new_access(i);
          else bus.req[i] = 1'b0;
        end else if (!bus.req[i] && $urandom_range(0, 3) == 0) new_access(i);
      end
  endtask

  task automatic tick();
    if (mode == 2) pc_ena = ($urandom_range(0, 2) == 0) ? 4'(SLOT) : 4'($urandom);
    else           pc_ena = pc_ena + 4'd1;
    predict();
    @(negedge clk);
    cycle_chk();
    req_update();
  endtask

  task automatic wait_gnts(input string tag, input int cnt);
    int n;
    n = 0;
    while (glog.size() < cnt && n < 200) begin tick(); n++; end
    chk(tag, 32'(glog.size()), 32'(cnt));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"}, 32'(bus.gnt), 0);
    chk({tag, "_rd_valid"}, 32'(bus.rd_valid), 0);
    chk({tag, "_rd_data"}, 32'(bus.rd_data), 0);
    chk({tag, "_wr_ena"}, 32'(bus.mem_wr_ena), 0);
    chk({tag, "_addr"}, 32'(bus.mem_addr), 0);
    chk({tag, "_wdata"}, 32'(bus.mem_wr_data), 0);
  endtask

  task automatic set_req(input int i, input logic wr, input logic [19:0] a, input logic [7:0] d);
    bus.req[i] = 1'b1; bus.req_wr[i] = wr; bus.req_addr[i] = a; bus.req_wdata[i] = d;
  endtask

  int exp_cont [4];
  int n;

  initial begin
    bus.req = '0; bus.req_wr = '0; bus.req_addr = '0; bus.req_wdata = '0;
    mode = 0; wrcnt = 0; gcyc = 0; rcyc = 0; last_rdd = '0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    reset_n = 1'b1;
    model_reset();

    // single write
    set_req(0, 1'b1, 20'h07C05, 8'hA5);
    wait_gnts("wr_gnt_seen", 1);
    repeat (3) tick();
    chk("wr_gnt_id", 32'(glog[0]), 0);
    chk("wr_pulses", 32'(wrcnt), 1);

    // single read
    glog.delete(); rdlog.delete();
    set_req(1, 1'b0, 20'h00010, 8'h00);
    n = 0;
    while (rdlog.size() == 0 && n < 60) begin tick(); n++; end
    chk("rd_seen", 32'(rdlog.size()), 1);
    chk("rd_id", 32'(rdlog.size() > 0 ? rdlog[0] : -1), 1);
    chk("rd_lat", 32'(rcyc - gcyc), 32'(RD_LAT + 2));
    chk("rd_value", 32'(last_rdd), 32'h3C);

    // contention, both held
    glog.delete(); mode = 1;
`ifdef HOST_ARB_PRIO0_EN
    exp_cont = '{0, 0, 0, 0};
`else
    exp_cont = '{0, 1, 0, 1};
`endif
    set_req(0, 1'b1, 20'h00100, 8'h11);
    set_req(1, 1'b1, 20'h00200, 8'h22);
    wait_gnts("cont_seen", 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("cont_gnt%0d", i), 32'(glog.size() > i ? glog[i] : -1), 32'(exp_cont[i]));
    mode = 0; bus.req = '0;
    repeat (4) tick();

    // pointer wrap 2 -> 0
    glog.delete();
    set_req(2, 1'b1, 20'h00300, 8'h33);
    wait_gnts("wrap_seen2", 1);
    set_req(0, 1'b1, 20'h00400, 8'h44);
    wait_gnts("wrap_seen0", 2);
    chk("wrap_first", 32'(glog[0]), 2);
    chk("wrap_second", 32'(glog.size() > 1 ? glog[1] : -1), 0);
    repeat (4) tick();

    // random traffic
    mode = 2;
    repeat (2000) tick();
    mode = 0; bus.req = '0;
    repeat (30) tick();
    chk("rand_drained", 32'(rq.size()), 0);

    // reset during RD_WAIT
    glog.delete(); rdlog.delete();
    set_req(1, 1'b0, 20'h00123, 8'h00);
    wait_gnts("rst_rd_gnt", 1);
    tick();
    reset_n = 1'b0;
    #1;
    chk_zero("midrd");
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    rdlog.delete();
    repeat (3 * RD_LAT + 10) tick();
    chk("no_rdv_after_rst", 32'(rdlog.size()), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
